ppu_slot_scheduler: RTL
=======================

// Module: ppu_slot_scheduler
// PURPOSE
//   Shares the PPU's limited entity channels among more game requesters than channels:
//   player, sword, sheep, hearts and extra dragon parts.
//   On each frame_end pulse it snapshots all requests and allocates PPU slots.
//   Pinned requesters are served first; the rest share the remaining slots round-robin.
//   The result is committed as one stable, double-buffered descriptor set for the next frame.
//   Sits between the game-logic blocks and the PPU entity_N inputs in tt_um top.
// PARAMETERS
//   N_REQ   8   number of requesters (>=2)
//   N_SLOT  4   number of PPU entity channels driven (1..N_REQ)
//   ENT_W   18  descriptor width: [17:14] spriteID, [13:12] orient, [11:4] tile xxxx_yyyy,
//               [3] flip, [2:0] array
// PORTS
//   clk          in   1               system clock
//   rst_n        in   1               synchronous, active-low reset
//   frame_end    in   1               1-cycle pulse from sync_generator; starts a schedule pass
//   req_valid    in   N_REQ           bit i: requester i wants a slot this frame
//   req_pinned   in   N_REQ           bit i: requester i allocated before all non-pinned
//   req_entity   in   N_REQ*ENT_W     descriptor i at [i*ENT_W +: ENT_W]
//   slot_entity  out  N_SLOT*ENT_W    committed descriptor per slot, to PPU entity inputs
//   slot_used    out  N_SLOT          bit s: slot s holds a granted requester
//   slot_owner   out  N_SLOT*IW       requester index per slot, IW=$clog2(N_REQ)
//   busy         out  1               high from the cycle after frame_end until COMMIT completes
//   overflow     out  1               committed frame dropped at least one valid request
//   drop_count   out  $clog2(N_REQ+1) number of valid requests dropped in the committed frame
// BEHAVIOUR
//   - DISABLED descriptor = 18'b1111_11_1111_1111_0_000 (spriteID 4'hF: PPU skips the channel).
//   - Reset, one cycle on rst_n low: all slot_entity=DISABLED, slot_used=0, slot_owner=0,
//     busy=0, overflow=0, drop_count=0, rr_ptr=0, FSM=IDLE.
//     Reset mid-pass abandons the pass; the back buffer is discarded.
//   - FSM: IDLE -> SNAP -> PIN -> RR -> COMMIT -> IDLE.
//   - IDLE: frame_end=1 -> SNAP.
//   - SNAP (1 cycle): latch req_valid, req_pinned and req_entity into shadow regs.
//     Clear the back buffer to DISABLED/unused. Clear the fill pointer and the drop counter.
//   - PIN (N_REQ cycles): idx i = 0..N_REQ-1, one per cycle.
//     If valid & pinned: place in slot[fill] and fill++ if fill<N_SLOT, else drop++.
//   - RR (N_REQ cycles): idx = (rr_ptr+k) mod N_REQ, k = 0..N_REQ-1.
//     If valid & ~pinned: same place/drop rule as PIN.
//     Record the index of the last non-pinned requester granted.
//   - COMMIT (1 cycle): copy the back buffer to slot_entity/slot_used/slot_owner.
//     Load overflow=(drop!=0) and drop_count.
//     If drop!=0 and a non-pinned requester was granted: rr_ptr <= (last_granted+1) mod N_REQ.
//     Otherwise rr_ptr is unchanged.
//   - Latency: outputs change on the clock edge 2*N_REQ+2 cycles after the frame_end edge
//     (18 for the defaults). They hold stable for the whole next frame.
//   - busy=1 in SNAP, PIN, RR and COMMIT. frame_end while busy is ignored (not queued).
//   - Only the shadow copy is used during the pass; input changes after SNAP have no effect.
//   - Slots fill in order 0,1,...; unfilled slots stay DISABLED with slot_used=0.
//   - Pinned requests beyond N_SLOT are dropped and counted like any other.
//   - drop_count saturates at N_REQ (cannot exceed it by construction).
// TESTING  (N_REQ=8, N_SLOT=4)
//   - Reset: rst_n=0 for 1 cycle -> all slots DISABLED, slot_used=0, busy=0, overflow=0.
//   - Light load: valid=8'b0101_0010, pinned=0, frame_end
//     -> 18 cycles later: owners 1,4,6 in slots 0..2; slot3 DISABLED; used=4'b0111; drop_count=0.
//   - Overflow fairness: valid=8'h3F, pinned=0, two frames.
//     -> Frame 1: owners 0,1,2,3; drop_count=2; overflow=1; rr_ptr=4.
//     -> Frame 2: owners 4,5,0,1.
//   - Pinning: valid=8'h9F, pinned=8'h80
//     -> slot0 owner 7; slots1..3 owners 0,1,2; drop_count=2.
//   - frame_end pulsed again 5 cycles into a pass -> ignored; exactly one commit at cycle 18.
//   - rst_n low during the RR phase -> next edge: outputs DISABLED, busy=0, rr_ptr=0.
//     The next frame_end schedules normally.

Source files
------------

// File: rtl/ppu_slot_scheduler.sv
// Per-frame allocator of PPU entity channels: snapshots requests on frame_end,
// grants pinned requesters first, then the rest round-robin, and commits a double-buffered slot set.
module ppu_slot_scheduler #(
    parameter  int N_REQ  = 8,
    parameter  int N_SLOT = 4,
    parameter  int ENT_W  = 18,
    localparam int IW     = $clog2(N_REQ),
    localparam int DW     = $clog2(N_REQ + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    frame_end,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ-1:0]        req_pinned,
    input  logic [N_REQ*ENT_W-1:0]  req_entity,
    output logic [N_SLOT*ENT_W-1:0] slot_entity,
    output logic [N_SLOT-1:0]       slot_used,
    output logic [N_SLOT*IW-1:0]    slot_owner,
    output logic                    busy,
    output logic                    overflow,
    output logic [DW-1:0]           drop_count
);

    localparam int FW = $clog2(N_SLOT + 1);
    localparam int SW = (N_SLOT > 1) ? $clog2(N_SLOT) : 1;
    localparam logic [ENT_W-1:0] DISABLED = ENT_W'(18'b1111_11_1111_1111_0_000);

    typedef enum logic [2:0] {IDLE, SNAP, PIN, RR, COMMIT} state_t;

    state_t state, next_state;

    logic [N_REQ-1:0]        sh_valid;
    logic [N_REQ-1:0]        sh_pinned;
    logic [N_REQ*ENT_W-1:0]  sh_entity;
    logic [N_SLOT*ENT_W-1:0] back_entity;
    logic [N_SLOT-1:0]       back_used;
    logic [N_SLOT*IW-1:0]    back_owner;
    logic [IW-1:0]           cnt;
    logic [IW-1:0]           rr_ptr;
    logic [IW-1:0]           cur_idx;
    logic [IW-1:0]           last_granted;
    logic                    rr_granted;
    logic [FW-1:0]           fill;
    logic [SW-1:0]           fill_idx;
    logic [DW-1:0]           drop;
    logic                    cand;
    logic [IW:0]             rr_sum;

    assign busy     = (state != IDLE);
    assign fill_idx = fill[SW-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (frame_end) next_state = SNAP;
            SNAP:    next_state = PIN;
            PIN:     if (cnt == IW'(N_REQ - 1)) next_state = RR;
            RR:      if (cnt == IW'(N_REQ - 1)) next_state = COMMIT;
            COMMIT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The RR walk starts at rr_ptr and wraps modulo N_REQ, which need not be a power of two.
    always_comb begin
        rr_sum  = {1'b0, rr_ptr} + {1'b0, cnt};
        cur_idx = cnt;
        cand    = 1'b0;
        if (state == RR) begin
            if (rr_sum >= (IW+1)'(N_REQ)) cur_idx = IW'(rr_sum - (IW+1)'(N_REQ));
            else                          cur_idx = rr_sum[IW-1:0];
        end
        if (state == PIN) cand = sh_valid[cur_idx] & sh_pinned[cur_idx];
        if (state == RR)  cand = sh_valid[cur_idx] & ~sh_pinned[cur_idx];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < N_SLOT; s++) begin
                slot_entity[s*ENT_W +: ENT_W] <= DISABLED;
                back_entity[s*ENT_W +: ENT_W] <= DISABLED;
            end
            slot_used    <= '0;
            slot_owner   <= '0;
            back_used    <= '0;
            back_owner   <= '0;
            overflow     <= 1'b0;
            drop_count   <= '0;
            rr_ptr       <= '0;
            cnt          <= '0;
            fill         <= '0;
            drop         <= '0;
            rr_granted   <= 1'b0;
            last_granted <= '0;
            sh_valid     <= '0;
            sh_pinned    <= '0;
            sh_entity    <= '0;
        end else begin
            case (state)
                SNAP: begin
                    sh_valid   <= req_valid;
                    sh_pinned  <= req_pinned;
                    sh_entity  <= req_entity;
                    for (int s = 0; s < N_SLOT; s++)
                        back_entity[s*ENT_W +: ENT_W] <= DISABLED;
                    back_used  <= '0;
                    back_owner <= '0;
                    cnt        <= '0;
                    fill       <= '0;
                    drop       <= '0;
                    rr_granted <= 1'b0;
                end
                PIN, RR: begin
                    if (cnt == IW'(N_REQ - 1)) cnt <= '0;
                    else                       cnt <= cnt + 1'b1;
                    if (cand) begin
                        if (fill < FW'(N_SLOT)) begin
                            back_entity[fill_idx*ENT_W +: ENT_W] <= sh_entity[cur_idx*ENT_W +: ENT_W];
                            back_used[fill_idx]                  <= 1'b1;
                            back_owner[fill_idx*IW +: IW]        <= cur_idx;
                            fill                                 <= fill + 1'b1;
                            if (state == RR) begin
                                rr_granted   <= 1'b1;
                                last_granted <= cur_idx;
                            end
                        end else if (drop < DW'(N_REQ)) begin
                            drop <= drop + 1'b1;
                        end
                    end
                end
                // The pointer only advances when someone actually lost out, so an
                // unloaded frame never perturbs the fairness order.
                COMMIT: begin
                    slot_entity <= back_entity;
                    slot_used   <= back_used;
                    slot_owner  <= back_owner;
                    overflow    <= (drop != '0);
                    drop_count  <= drop;
                    if ((drop != '0) && rr_granted) begin
                        if (last_granted == IW'(N_REQ - 1)) rr_ptr <= '0;
                        else                                rr_ptr <= last_granted + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
